// File: rtl/hmc_tx_token_ctrl_pkg.sv
// Shared HMC token-flow definitions: widths, packet limits and the
// link token state machine encoding used by the TX and RX token blocks.
package hmc_tx_token_ctrl_pkg;

    localparam int HMC_TOKEN_W   = 10;
    localparam int MAX_PKT_FLITS = 9;
    localparam int RTC_FIELD_W   = 5;

    typedef enum logic [1:0] {
        TOK_IDLE,
        TOK_LOAD,
        TOK_RUN,
        TOK_ERR
    } tok_state_e;

    function automatic logic lng_legal(input logic [3:0] lng);
        return (lng != 4'd0) && (lng <= 4'(MAX_PKT_FLITS));
    endfunction

endpackage

// File: rtl/hmc_tx_token_ctrl_sat_counter.sv
// Parametric saturating up-counter; holds at all-ones instead of wrapping.
module hmc_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_count = r_cnt;

endmodule

// File: rtl/hmc_tx_token_ctrl.sv
// TX credit manager: gates packet issue on HMC input-buffer tokens,
// deducts on accept and replenishes from RX return-token counts.
module hmc_tx_token_ctrl
    import hmc_tx_token_ctrl_pkg::*;
#(
    parameter int FPW                = 4,
    parameter int LOG_FPW            = $clog2(FPW),
    parameter int LOG_MAX_HMC_TOKENS = HMC_TOKEN_W,
    parameter int STALL_CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic [LOG_MAX_HMC_TOKENS-1:0] rf_tokens_init,
    input  logic                          rf_link_up,
    input  logic                          tx_req_valid,
    input  logic [3:0]                    tx_req_lng,
    output logic                          tx_req_ready,
    input  logic                          rx_rtc_valid,
    input  logic [RTC_FIELD_W+LOG_FPW-1:0] rx_rtc,
    output logic [LOG_MAX_HMC_TOKENS-1:0] tokens_av,
    output logic [STALL_CNT_W-1:0]        stall_cnt,
    output logic                          err_overflow,
    output logic                          err_lng
);

    localparam int TW  = LOG_MAX_HMC_TOKENS;
    localparam int RCW = RTC_FIELD_W + LOG_FPW;

    tok_state_e    r_state;
    tok_state_e    w_state_nxt;
    logic [TW-1:0] r_tokens;
    logic [TW-1:0] w_tokens_nxt;
    logic          r_err_ovf;
    logic          r_err_lng;
    logic          w_ovf_set;

    logic          w_run;
    logic          w_lng_ok;
    logic          w_ready;
    logic          w_accept;
    logic [TW:0]   w_lng_ext;
    logic [TW:0]   w_sub;
    logic [TW:0]   w_add;
    logic [TW:0]   w_sum;

    assign w_run     = (r_state == TOK_RUN);
    assign w_lng_ok  = lng_legal(tx_req_lng);
    assign w_lng_ext = {{(TW-3){1'b0}}, tx_req_lng};

    // Ready looks only at the registered count; same-cycle RTC is not credited.
    assign w_ready  = w_run && w_lng_ok && ({1'b0, r_tokens} >= w_lng_ext);
    assign w_accept = tx_req_valid && w_ready;

    assign w_sub = w_accept ? w_lng_ext : '0;
    assign w_add = rx_rtc_valid ? {{(TW+1-RCW){1'b0}}, rx_rtc} : '0;
    assign w_sum = {1'b0, r_tokens} - w_sub + w_add;

    always_comb begin
        w_state_nxt  = r_state;
        w_tokens_nxt = r_tokens;
        w_ovf_set    = 1'b0;
        unique case (r_state)
            TOK_IDLE: begin
                if (rf_link_up) begin
                    w_state_nxt = TOK_LOAD;
                end
            end
            TOK_LOAD: begin
                w_tokens_nxt = rf_tokens_init;
                w_state_nxt  = TOK_RUN;
            end
            TOK_RUN: begin
                if (!rf_link_up) begin
                    w_tokens_nxt = '0;
                    w_state_nxt  = TOK_IDLE;
                end else if (w_sum[TW]) begin
                    w_tokens_nxt = '1;
                    w_ovf_set    = 1'b1;
                    w_state_nxt  = TOK_ERR;
                end else begin
                    w_tokens_nxt = w_sum[TW-1:0];
                end
            end
            TOK_ERR: begin
                w_state_nxt = TOK_ERR;
            end
            default: begin
                w_state_nxt = TOK_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state   <= TOK_IDLE;
            r_tokens  <= '0;
            r_err_ovf <= 1'b0;
            r_err_lng <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tokens <= w_tokens_nxt;
            if (w_ovf_set) begin
                r_err_ovf <= 1'b1;
            end
            if (tx_req_valid && !w_lng_ok) begin
                r_err_lng <= 1'b1;
            end
        end
    end

    hmc_sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .res_n   (res_n),
        .i_inc   (w_run && tx_req_valid && !w_ready),
        .o_count (stall_cnt)
    );

    assign tx_req_ready = w_ready;
    assign tokens_av    = r_tokens;
    assign err_overflow = r_err_ovf;
    assign err_lng      = r_err_lng;

endmodule
